// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 raster timing, counter/line-buffer widths and the
// per-pixel control bundle carried down the alignment pipeline.
`default_nettype none

package vga_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int H_TOT_D    = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;

  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;
  localparam int V_TOT_D    = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

  localparam int LB_LAT_D   = 2;

  localparam int HCW   = 11;
  localparam int VCW   = 10;
  localparam int LB_AW = 10;
  localparam int LB_DW = 24;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic frame;
  } stage_t;

endpackage

`default_nettype wire

// File: rtl/vga_timing.sv
// vga_timing: horizontal/vertical counters, enable hold and stage-0 decode of
// act/hs/vs/frame plus the registered line request toward the upstream filler.
`default_nettype none

module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input  logic             sys_clk,
  input  logic             resetl,
  input  logic             en,
  output logic [LB_AW-1:0] pix_x,
  output stage_t           st0,
  output logic             line_req,
  output logic [VCW-1:0]   req_line
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOT - 1);
  localparam logic [HCW-1:0] H_ACT    = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] HS_START = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HS_END   = HCW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOT - 1);
  localparam logic [VCW-1:0] V_ACT    = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] VS_START = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VS_END   = VCW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HCW-1:0] hcnt;
  logic [VCW-1:0] vcnt;
  logic [VCW-1:0] vcnt_inc;
  logic [VCW-1:0] next_line;
  logic           hblank;
  logic           req_now;
  logic           boot;

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (en) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VCW'(1);
      end else begin
        hcnt <= hcnt + HCW'(1);
      end
    end
  end

  always_comb begin
    st0.act   = (hcnt < H_ACT) && (vcnt < V_ACT) && en;
    st0.hs    = (hcnt >= HS_START) && (hcnt < HS_END);
    st0.vs    = (vcnt >= VS_START) && (vcnt < VS_END);
    st0.frame = (hcnt == '0) && (vcnt == '0) && en;
    pix_x     = hcnt[LB_AW-1:0];
    vcnt_inc  = vcnt + VCW'(1);
    next_line = (vcnt_inc < V_ACT) ? vcnt_inc : '0;
    hblank    = (hcnt == H_ACT);
    req_now   = en && (hblank || boot);
  end

  // The pulse is registered so req_line can be held stable between requests;
  // it appears one clock after hcnt==H_ACTIVE is decoded. boot asks for line 0
  // on the first enabled clock after reset.
  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      line_req <= 1'b0;
      req_line <= '0;
      boot     <= 1'b1;
    end else begin
      line_req <= req_now;
      if (req_now) begin
        req_line <= hblank ? next_line : '0;
      end
      if (en) begin
        boot <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vgalb_scan.sv
// vgalb_scan: line-buffer scan-out with VGA timing; aligns de/syncs to the
// 2-cycle buffer read. Macro VGALB_SCAN_CLEAR_EN enables clear-on-read.
`default_nettype none

module vgalb_scan
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int LB_LAT   = LB_LAT_D
) (
  input  logic             sys_clk,
  input  logic             resetl,
  input  logic             en,
  output logic [LB_AW-1:0] lb_a,
  output logic             lb_we,
  output logic [LB_DW-1:0] lb_d,
  input  logic [LB_DW-1:0] lb_q,
  output logic [LB_DW-1:0] rgb,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             de,
  output logic             line_req,
  output logic [VCW-1:0]   req_line,
  output logic             frame_start
);

  stage_t           st0;
  stage_t           pipe [LB_LAT];
  stage_t           st_out;
  logic [LB_AW-1:0] pix_x;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .sys_clk  (sys_clk),
    .resetl   (resetl),
    .en       (en),
    .pix_x    (pix_x),
    .st0      (st0),
    .line_req (line_req),
    .req_line (req_line)
  );

  assign lb_a = st0.act ? pix_x : '0;

  // Control bits ride a pipeline exactly as deep as the buffer read, so they
  // meet the data for the pixel addressed LB_LAT clocks earlier.
  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      for (int i = 0; i < LB_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= st0;
      for (int i = 1; i < LB_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign st_out      = pipe[LB_LAT-1];
  assign de          = st_out.act;
  assign hsync_n     = ~st_out.hs;
  assign vsync_n     = ~st_out.vs;
  assign frame_start = st_out.frame;
  assign rgb         = de ? lb_q : '0;

`ifdef VGALB_SCAN_CLEAR_EN
  // Read-before-write: the old pixel is returned while black is stored.
  assign lb_we = st0.act & resetl;
`else
  assign lb_we = 1'b0;
`endif
  assign lb_d = '0;

endmodule

`default_nettype wire

// File: tb/tb_vgalb_scan.sv
// tb_vgalb_scan: scoreboard bench for vgalb_scan on a reduced raster, with a
// 2-cycle registered line-buffer model (read-before-write).
`default_nettype none

module tb_vgalb_scan;

  localparam int HA = 20, HF = 3, HS = 5, HB = 4;
  localparam int VA = 6, VF = 2, VS = 2, VB = 3;
  localparam int LAT = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
`ifdef VGALB_SCAN_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  typedef struct packed {
    logic        de;
    logic [23:0] rgb;
    logic        hs_n;
    logic        vs_n;
    logic        fs;
  } exp_t;
  localparam exp_t ZOUT = '{1'b0, 24'h0, 1'b1, 1'b1, 1'b0};

  logic        sys_clk = 1'b0;
  logic        resetl  = 1'b0;
  logic        en      = 1'b1;
  logic [9:0]  lb_a;
  logic        lb_we;
  logic [23:0] lb_d;
  logic [23:0] lb_q;
  logic [23:0] rgb;
  logic        hsync_n, vsync_n, de, line_req, frame_start;
  logic [9:0]  req_line;

  always #5 sys_clk = ~sys_clk;

  vgalb_scan #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .LB_LAT   (LAT)
  ) dut (
    .sys_clk     (sys_clk),
    .resetl      (resetl),
    .en          (en),
    .lb_a        (lb_a),
    .lb_we       (lb_we),
    .lb_d        (lb_d),
    .lb_q        (lb_q),
    .rgb         (rgb),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .de          (de),
    .line_req    (line_req),
    .req_line    (req_line),
    .frame_start (frame_start)
  );

  function automatic logic [23:0] pre_val(int i);
    return CLR ? 24'hFFFFFF : 24'(i);
  endfunction

  // Line buffer model: registered 2-cycle read, old data returned on write.
  logic [23:0] mem [1024];
  logic [23:0] q1, q2;
  logic        preload = 1'b1;
  always @(posedge sys_clk) begin
    q1 <= mem[lb_a];
    q2 <= q1;
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pre_val(i);
    end else if (lb_we) begin
      mem[lb_a] <= lb_d;
    end
  end
  assign lb_q = q2;

  exp_t        sbq[$];
  logic [23:0] img [1024];
  int          mh = 0, mv = 0;
  logic        pend = 1'b1;
  logic        exp_lr = 1'b0;
  logic [9:0]  exp_rl = '0;
  int          vectors = 0, miscompares = 0;
  int          de_cnt = 0, lr_cnt = 0, fs_cnt = 0, we_cnt = 0, nz_cnt = 0;

  // Predict the coming edge from current inputs, then compare at the negedge.
  task automatic cycle();
    exp_t        e;
    logic        act, hs, vs, fr, lr_now, we_exp;
    logic [9:0]  a_exp;
    act = (mh < HA) && (mv < VA) && en;
    hs  = (mh >= HA + HF) && (mh < HA + HF + HS);
    vs  = (mv >= VA + VF) && (mv < VA + VF + VS);
    fr  = (mh == 0) && (mv == 0) && en;
    if (!resetl) begin
      sbq.delete();
      for (int i = 0; i < LAT; i++) sbq.push_back(ZOUT);
      mh = 0; mv = 0; exp_lr = 1'b0; exp_rl = '0; pend = 1'b1;
    end else begin
      e.de = act; e.rgb = act ? img[mh] : 24'h0;
      e.hs_n = ~hs; e.vs_n = ~vs; e.fs = fr;
      sbq.push_back(e);
      lr_now = en && ((mh == HA) || pend);
      exp_lr = lr_now;
      if (lr_now) exp_rl = (mh == HA) ? ((mv + 1 < VA) ? 10'(mv + 1) : 10'd0) : 10'd0;
      if (en) pend = 1'b0;
      if (CLR && act) img[mh] = 24'h0;
      if (en) begin
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh = mh + 1;
        end
      end
    end
    @(negedge sys_clk);
    e = sbq.pop_front();
    vectors++;
    if (de !== e.de || rgb !== e.rgb || hsync_n !== e.hs_n || vsync_n !== e.vs_n || frame_start !== e.fs) begin
      miscompares++;
      $display("FAIL pipe_out t=%0t got de=%b rgb=%h hs_n=%b vs_n=%b fs=%b want de=%b rgb=%h hs_n=%b vs_n=%b fs=%b",
               $time, de, rgb, hsync_n, vsync_n, frame_start, e.de, e.rgb, e.hs_n, e.vs_n, e.fs);
    end
    vectors++;
    if (line_req !== exp_lr || req_line !== exp_rl) begin
      miscompares++;
      $display("FAIL line_req t=%0t got req=%b line=%0d want req=%b line=%0d",
               $time, line_req, req_line, exp_lr, exp_rl);
    end
    act    = (mh < HA) && (mv < VA) && en;
    a_exp  = act ? 10'(mh) : 10'd0;
    we_exp = CLR && act && resetl;
    vectors++;
    if (lb_a !== a_exp || lb_we !== we_exp || lb_d !== 24'h0) begin
      miscompares++;
      $display("FAIL lb_port t=%0t got a=%0d we=%b d=%h want a=%0d we=%b d=000000",
               $time, lb_a, lb_we, lb_d, a_exp, we_exp);
    end
    de_cnt += int'(de); lr_cnt += int'(line_req); fs_cnt += int'(frame_start);
    we_cnt += int'(lb_we); nz_cnt += int'(rgb != 24'h0);
  endtask

  task automatic seek(int h, int v);
    for (int i = 0; i < HT * VT + 1 && !(mh == h && mv == v); i++) cycle();
    vectors++;
    if (mh != h || mv != v) begin
      miscompares++;
      $display("FAIL seek got h=%0d v=%0d want h=%0d v=%0d", mh, mv, h, v);
    end
  endtask

  task automatic test_reset();
    resetl = 1'b0; en = 1'b1;
    repeat (5) cycle();
    preload = 1'b0;
    vectors++;
    if (hsync_n !== 1'b1 || vsync_n !== 1'b1 || de !== 1'b0 || rgb !== 24'h0 || line_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got hs_n=%b vs_n=%b de=%b rgb=%h lr=%b want 1 1 0 000000 0",
               hsync_n, vsync_n, de, rgb, line_req);
    end
    resetl = 1'b1;
    cycle();
    vectors++;
    if (line_req !== 1'b1 || req_line !== 10'd0) begin
      miscompares++;
      $display("FAIL boot_req got lr=%b line=%0d want 1 0", line_req, req_line);
    end
    cycle();
    vectors++;
    if (frame_start !== 1'b1 || de !== 1'b1 || rgb !== pre_val(0)) begin
      miscompares++;
      $display("FAIL first_pixel got fs=%b de=%b rgb=%h want 1 1 %h", frame_start, de, rgb, pre_val(0));
    end
  endtask

  task automatic test_scan();
    seek(0, 0);
    de_cnt = 0; lr_cnt = 0; fs_cnt = 0;
    repeat (2 * HT * VT) cycle();
    vectors++;
    if (de_cnt != 2 * HA * VA || lr_cnt != 2 * VT || fs_cnt != 2) begin
      miscompares++;
      $display("FAIL frame_counts got de=%0d lr=%0d fs=%0d want de=%0d lr=%0d fs=2",
               de_cnt, lr_cnt, fs_cnt, 2 * HA * VA, 2 * VT);
    end
  endtask

  task automatic test_en_pause();
    int lr0;
    seek(10, 1);
    en = 1'b0;
    #1;
    vectors++;
    if (lb_a !== 10'd0 || lb_we !== 1'b0) begin
      miscompares++;
      $display("FAIL pause_addr got a=%0d we=%b want 0 0", lb_a, lb_we);
    end
    lr0 = lr_cnt;
    repeat (8) cycle();
    vectors++;
    if (de !== 1'b0 || lr_cnt != lr0) begin
      miscompares++;
      $display("FAIL pause_hold got de=%b new_req=%0d want 0 0", de, lr_cnt - lr0);
    end
    en = 1'b1;
    #1;
    vectors++;
    if (lb_a !== 10'd10) begin
      miscompares++;
      $display("FAIL resume_addr got a=%0d want 10", lb_a);
    end
    repeat (2 * HT) cycle();
  endtask

  task automatic test_reset_midline();
    seek(HA + HF + 1, 3);
    resetl = 1'b0;
    cycle();
    vectors++;
    if (hsync_n !== 1'b1 || de !== 1'b0 || line_req !== 1'b0 || frame_start !== 1'b0) begin
      miscompares++;
      $display("FAIL midline_reset got hs_n=%b de=%b lr=%b fs=%b want 1 0 0 0",
               hsync_n, de, line_req, frame_start);
    end
    resetl = 1'b1;
    repeat (HT * VT + HT) cycle();
  endtask

  task automatic test_clear_path();
    seek(0, 0);
    we_cnt = 0; nz_cnt = 0;
    repeat (HT * VT) cycle();
    vectors++;
    if (we_cnt != (CLR ? HA * VA : 0) || nz_cnt != (CLR ? 0 : VA * (HA - 1))) begin
      miscompares++;
      $display("FAIL clear_path got we=%0d nonzero=%0d want we=%0d nonzero=%0d",
               we_cnt, nz_cnt, CLR ? HA * VA : 0, CLR ? 0 : VA * (HA - 1));
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) img[i] = pre_val(i);
    test_reset();
    test_scan();
    test_en_pause();
    test_reset_midline();
    test_clear_path();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at t=%0t", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/vgalb_scan.md
Name: vgalb_scan

Overview:
- Downstream consumer of the 1024x24 single-port VGA line buffer, which has a 2-cycle registered read.
- Generates VGA raster timing and drives the line buffer address so pixels reach the output in step with hsync, vsync and de.
- Requests the next line from the upstream filler during horizontal blanking.
- Optionally clears each pixel as it is read, using the buffer's read-before-write behaviour.

Parameters:
- H_ACTIVE, 640, visible pixels per line (must be <= 1024)
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- LB_LAT, 2, line buffer read latency; the output pipeline depth equals this value

Ports:
- sys_clk  in  1  single clock; every register is on the rising edge
- resetl  in  1  synchronous, active-low reset
- en  in  1  timing enable; counters advance only while high
- lb_a  out  10  line buffer address
- lb_we  out  1  line buffer write enable
- lb_d  out  24  line buffer write data
- lb_q  in  24  line buffer read data, valid LB_LAT clocks after lb_a
- rgb  out  24  pixel out {R[23:16],G[15:8],B[7:0]}; 0 when de=0
- hsync_n  out  1  horizontal sync, active low
- vsync_n  out  1  vertical sync, active low
- de  out  1  display enable
- line_req  out  1  one-clock pulse asking upstream to fill line req_line
- req_line  out  10  line number for line_req; stable until the next pulse
- frame_start  out  1  one-clock pulse, aligned with de for pixel (0,0)

Behaviour:
- Counters:
  - hcnt: 11 bits, 0..H_TOT-1, where H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - vcnt: 10 bits, 0..V_TOT-1 (525).
  - hcnt wraps to 0 after H_TOT-1; vcnt increments on that wrap and itself wraps to 0 after V_TOT-1.
  - en=0: both counters hold. The stage-0 de/hs/vs values are recomputed from the held counts, so outputs freeze after the pipeline drains.
- Stage-0 decode:
  - act = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE) && en.
  - hs = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs = vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Address: lb_a = hcnt[9:0] when act, else 0. lb_a is combinational from the registered counters.
- Alignment:
  - act, hs, vs and the frame-start flag travel through an LB_LAT-deep register pipeline.
  - de = act delayed by LB_LAT; hsync_n = ~hs delayed; vsync_n = ~vs delayed.
  - rgb = de ? lb_q : 0. The pixel read at hcnt=N appears on rgb exactly LB_LAT clocks later.
- Line request:
  - line_req pulses for one clock when hcnt==H_ACTIVE (start of hblank) and en=1.
  - req_line = vcnt+1 if that is < V_ACTIVE, else 0, so line 0 is prefetched during vblank.
  - Line 0 is also requested on the first enabled clock after reset.
- frame_start: stage-0 flag set when hcnt==0 && vcnt==0 && en, then delayed LB_LAT clocks.
- Without the clear feature: lb_we=0 and lb_d=0 at all times.
- Reset (resetl=0 at the clock edge), values take effect that edge:
  - Counters and pipeline: hcnt=0, vcnt=0, all pipeline stages cleared.
  - Outputs: de=0, rgb=0, hsync_n=1, vsync_n=1, line_req=0, req_line=0, frame_start=0, lb_we=0, lb_d=0.
  - Reset asserted mid-line aborts the line immediately, with no partial sync pulse extension.
- Boundaries:
  - The last active pixel (hcnt=H_ACTIVE-1) still produces de on the output.
  - hcnt==H_ACTIVE drives lb_a=0 and de stage-0 = 0.
  - vcnt wrap and hcnt wrap on the same clock produce frame_start LB_LAT clocks later.

Optional Feature:
- Macro: VGALB_SCAN_CLEAR_EN.
- Defined: lb_we = act and lb_d = 24'h000000 on every active read. The buffer returns the old data (read-before-write) and stores black, so any pixel the upstream filler does not rewrite displays black.
- Undefined: lb_we is tied to 0 and no write path is synthesized.

Decomposition:
- Package vga_pkg:
  - default 640x480@60 timing constants and H_TOT/V_TOT derivation;
  - counter width localparams (HCW=11, VCW=10);
  - LB_AW=10 and LB_DW=24.
- One natural sub-module, vga_timing: counters, en handling, stage-0 decode (act/hs/vs/line_req/frame flag).
- vgalb_scan instantiates vga_timing and adds address generation, the LB_LAT alignment pipeline and the clear path.

Test Plan:
- Reset held 5 clocks with en=1 -> hsync_n=1, vsync_n=1, de=0, rgb=0 throughout; after release, frame_start pulses on clock 3 (LB_LAT+1) with de=1.
- Line buffer model preloaded with mem[i]=i, free-running -> rgb=24'h000000..24'h00027F on consecutive de clocks; de high for exactly 640 clocks per line; first lb_a=0 precedes first rgb by 2 clocks.
- Full frame count -> hsync_n low for 96 clocks starting 656 clocks after de rises; vsync_n low for 2 lines (1600 clocks) starting after line 489; frame period 420000 clocks.
- Line request -> during line 5, line_req pulses at hcnt=640 with req_line=6; at line 479 req_line=0; pulse counted once per line (525 per frame).
- en dropped at hcnt=100 for 50 clocks -> counters hold, de falls 2 clocks later, no line_req; resume continues from hcnt=100.
- VGALB_SCAN_CLEAR_EN defined, mem preloaded with 24'hFFFFFF, no refill -> frame 1 rgb=FFFFFF; frame 2 rgb=000000; lb_we high exactly while de stage-0 active.
